// File: rtl/aoc_pkg.sv
// Shared constants, widths and FSM encoding for the rotation command front end.
package aoc_pkg;

  localparam int unsigned COUNT_W_DEF = 10;
  localparam int unsigned LINE_W_DEF  = 16;

  localparam logic [7:0] ASCII_L  = 8'h4C;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DIR_SEEN = 3'd1,
    NUM      = 3'd2,
    DONE     = 3'd3,
    ERR      = 3'd4
  } seq_state_e;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/rotation_cmd_sequencer_dec_accum.sv
// Decimal accumulator: clear / load first digit / shift in next digit, with a
// combinational next value and an overflow flag computed four bits wider.
module dec_accum #(
  parameter int unsigned COUNT_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic               shift_i,
  input  logic [3:0]         digit_i,
  output logic [COUNT_W-1:0] acc_o,
  output logic [COUNT_W-1:0] acc_nxt_o_c,
  output logic               ovf_o_c
);

  localparam int unsigned EXT_W = COUNT_W + 4;
  localparam logic [EXT_W-1:0] MAX_EXT = {4'd0, {COUNT_W{1'b1}}};

  logic [COUNT_W-1:0] acc_q, acc_d;
  logic [EXT_W-1:0]   shifted;

  // acc*10 + d cannot exceed 2^(COUNT_W+4)-1 when acc fits in COUNT_W bits
  assign shifted = EXT_W'(acc_q) * EXT_W'(10) + EXT_W'(digit_i);
  assign ovf_o_c = shifted > MAX_EXT;

  always_comb begin
    acc_d = acc_q;
    if (clear_i)      acc_d = '0;
    else if (load_i)  acc_d = COUNT_W'(digit_i);
    else if (shift_i) acc_d = shifted[COUNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_o       = acc_q;
  assign acc_nxt_o_c = acc_d;

endmodule

// File: rtl/rotation_cmd_sequencer.sv
// Parses "L68\n"-style ASCII lines into single-cycle step commands, flagging
// end of input (done) and malformed input (err).
module rotation_cmd_sequencer
  import aoc_pkg::*;
#(
  parameter int unsigned COUNT_W = COUNT_W_DEF,
  parameter int unsigned LINE_W  = LINE_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic               step_valid,
  output logic               step_direction,
  output logic [COUNT_W-1:0] step_count,
  output logic               done,
  output logic               err,
  output logic [LINE_W-1:0]  line_count
);

  seq_state_e state_q, state_d, parse_c;

  logic               in_ready_q, in_ready_d;
  logic               step_valid_q, step_valid_d;
  logic               step_dir_q, step_dir_d;
  logic [COUNT_W-1:0] step_count_q, step_count_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic               dir_q, dir_d;

  logic               accept_c, is_lf_c, is_cr_c, is_dir_c, is_dig_c, issue_c;
  logic               acc_clr_c, acc_ld_c, acc_sh_c, acc_ovf_c;
  logic [3:0]         digit_c;
  logic [COUNT_W-1:0] acc_q, acc_nxt_c;

  assign accept_c = in_valid && in_ready_q;
  assign is_lf_c  = in_data == ASCII_LF;
  assign is_cr_c  = in_data == ASCII_CR;
  assign is_dir_c = (in_data == ASCII_L) || (in_data == ASCII_R);
  assign is_dig_c = is_digit(in_data);
  assign digit_c  = 4'(in_data - ASCII_0);

  dec_accum #(.COUNT_W(COUNT_W)) u_accum (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (acc_clr_c),
    .load_i     (acc_ld_c),
    .shift_i    (acc_sh_c),
    .digit_i    (digit_c),
    .acc_o      (acc_q),
    .acc_nxt_o_c(acc_nxt_c),
    .ovf_o_c    (acc_ovf_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Parse the byte first, then let in_last redirect the resulting state.
  always_comb begin
    parse_c = state_q;
    state_d = state_q;
    if (accept_c && !is_cr_c) begin
      case (state_q)
        IDLE: begin
          if (is_dir_c)     parse_c = DIR_SEEN;
          else if (!is_lf_c) parse_c = ERR;
        end
        DIR_SEEN: parse_c = is_dig_c ? NUM : ERR;
        NUM: begin
          if (is_lf_c)                     parse_c = IDLE;
          else if (!is_dig_c || acc_ovf_c) parse_c = ERR;
        end
        default: parse_c = state_q;
      endcase
    end
    state_d = parse_c;
    if (accept_c && in_last) begin
      case (parse_c)
        IDLE, NUM: state_d = DONE;
        DIR_SEEN:  state_d = ERR;
        default:   state_d = parse_c;
      endcase
    end
  end

  always_comb begin
    acc_clr_c = 1'b0;
    acc_ld_c  = 1'b0;
    acc_sh_c  = 1'b0;
    if (accept_c && !is_cr_c) begin
      case (state_q)
        IDLE:     acc_clr_c = is_dir_c;
        DIR_SEEN: acc_ld_c  = is_dig_c;
        NUM:      acc_sh_c  = is_dig_c;
        default:  acc_clr_c = 1'b0;
      endcase
    end
    // A line ends on LF in NUM, or on in_last while a number is pending
    issue_c = accept_c && (((state_q == NUM) && is_lf_c) ||
                           (in_last && (parse_c == NUM)));

    dir_d        = (accept_c && (state_q == IDLE) && is_dir_c) ? (in_data == ASCII_R) : dir_q;
    step_valid_d = issue_c;
    step_dir_d   = issue_c ? dir_q : step_dir_q;
    step_count_d = issue_c ? acc_nxt_c : step_count_q;
    line_d       = (issue_c && (line_q != '1)) ? line_q + LINE_W'(1) : line_q;
    done_d       = state_q == DONE;
    err_d        = state_d == ERR;
    in_ready_d   = (state_d == IDLE) || (state_d == DIR_SEEN) || (state_d == NUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q   <= 1'b0;
      step_valid_q <= 1'b0;
      step_dir_q   <= 1'b0;
      step_count_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      line_q       <= '0;
      dir_q        <= 1'b0;
    end else begin
      in_ready_q   <= in_ready_d;
      step_valid_q <= step_valid_d;
      step_dir_q   <= step_dir_d;
      step_count_q <= step_count_d;
      done_q       <= done_d;
      err_q        <= err_d;
      line_q       <= line_d;
      dir_q        <= dir_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign step_valid     = step_valid_q;
  assign step_direction = step_dir_q;
  assign step_count     = step_count_q;
  assign done           = done_q;
  assign err            = err_q;
  assign line_count     = line_q;

endmodule

// File: tb/tb_rotation_cmd_sequencer.sv
// Directed bench for rotation_cmd_sequencer: line parsing, timing, errors and reset.
module tb_rotation_cmd_sequencer;

  localparam int unsigned CW = 10;
  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          step_valid;
  logic          step_direction;
  logic [CW-1:0] step_count;
  logic          done;
  logic          err;
  logic [LW-1:0] line_count;

  int checks = 0;
  int failures = 0;
  logic [CW:0] obs[$];

  rotation_cmd_sequencer #(.COUNT_W(CW), .LINE_W(LW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .step_valid    (step_valid),
    .step_direction(step_direction),
    .step_count    (step_count),
    .done          (done),
    .err           (err),
    .line_count    (line_count)
  );

  always #5 clk = ~clk;

  // Every step pulse is recorded as {direction, count}
  always @(negedge clk) begin
    if (rst_n && step_valid) obs.push_back({step_direction, step_count});
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    obs.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
    int waited = 0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data = 8'h58;
    end
    @(negedge clk);
    in_data = b;
    in_valid = 1'b1;
    in_last = last;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: byte %h not accepted, in_ready=%b expected 1", b, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({in_ready, step_valid, step_direction, step_count, done, err, line_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b sv=%b dir=%b cnt=%0d done=%b err=%b lines=%0d expected all 0",
               in_ready, step_valid, step_direction, step_count, done, err, line_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic test_two_lines();
    do_reset();
    send_byte(8'h4C, 1'b0, 0);
    send_byte(8'h36, 1'b0, 0);
    send_byte(8'h38, 1'b0, 0);
    send_byte(8'h0A, 1'b0, 0);
    checks++;
    if ({step_valid, step_direction, step_count, line_count} !== {1'b1, 1'b0, 10'd68, 16'd1}) begin
      failures++;
      $display("FAIL l68_pulse: got sv=%b dir=%b cnt=%0d lines=%0d expected 1 0 68 1",
               step_valid, step_direction, step_count, line_count);
    end
    send_byte(8'h52, 1'b0, 0);
    send_byte(8'h35, 1'b0, 0);
    send_byte(8'h0A, 1'b1, 0);
    checks++;
    if ({step_valid, step_direction, step_count, line_count, done} !== {1'b1, 1'b1, 10'd5, 16'd2, 1'b0}) begin
      failures++;
      $display("FAIL r5_pulse: got sv=%b dir=%b cnt=%0d lines=%0d done=%b expected 1 1 5 2 0",
               step_valid, step_direction, step_count, line_count, done);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({step_valid, done, err, in_ready} !== 4'b0100) begin
      failures++;
      $display("FAIL two_lines_done: got sv=%b done=%b err=%b rdy=%b expected 0 1 0 0",
               step_valid, done, err, in_ready);
    end
    checks++;
    if (obs.size() != 2) begin
      failures++;
      $display("FAIL two_lines_count: got %0d pulses expected 2", obs.size());
    end
  endtask

  task automatic test_crlf_blank_last_digit();
    do_reset();
    send_byte(8'h52, 1'b0, 0);
    send_byte(8'h31, 1'b0, 0);
    send_byte(8'h30, 1'b0, 0);
    send_byte(8'h0D, 1'b0, 0);
    send_byte(8'h0A, 1'b0, 0);
    checks++;
    if ({step_valid, step_direction, step_count} !== {1'b1, 1'b1, 10'd10}) begin
      failures++;
      $display("FAIL r10_pulse: got sv=%b dir=%b cnt=%0d expected 1 1 10", step_valid, step_direction, step_count);
    end
    send_byte(8'h0A, 1'b0, 0);
    checks++;
    if (step_valid !== 1'b0) begin
      failures++;
      $display("FAIL blank_line: step_valid=%b expected 0", step_valid);
    end
    send_byte(8'h4C, 1'b0, 0);
    send_byte(8'h30, 1'b0, 0);
    send_byte(8'h30, 1'b0, 0);
    send_byte(8'h31, 1'b1, 0);
    checks++;
    if ({step_valid, step_direction, step_count, done} !== {1'b1, 1'b0, 10'd1, 1'b0}) begin
      failures++;
      $display("FAIL l001_pulse: got sv=%b dir=%b cnt=%0d done=%b expected 1 0 1 0",
               step_valid, step_direction, step_count, done);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({done, err, line_count} !== {1'b1, 1'b0, 16'd2} || obs.size() != 2) begin
      failures++;
      $display("FAIL crlf_done: got done=%b err=%b lines=%0d pulses=%0d expected 1 0 2 2",
               done, err, line_count, obs.size());
    end
  endtask

  task automatic test_overflow();
    do_reset();
    send_byte(8'h52, 1'b0, 0);
    send_byte(8'h31, 1'b0, 0);
    send_byte(8'h30, 1'b0, 0);
    send_byte(8'h32, 1'b0, 0);
    send_byte(8'h33, 1'b0, 0);
    send_byte(8'h0A, 1'b0, 0);
    checks++;
    if ({step_valid, step_direction, step_count} !== {1'b1, 1'b1, 10'd1023}) begin
      failures++;
      $display("FAIL r1023_pulse: got sv=%b dir=%b cnt=%0d expected 1 1 1023", step_valid, step_direction, step_count);
    end
    send_byte(8'h52, 1'b0, 0);
    send_byte(8'h31, 1'b0, 0);
    send_byte(8'h30, 1'b0, 0);
    send_byte(8'h32, 1'b0, 0);
    send_byte(8'h34, 1'b0, 0);
    checks++;
    if ({err, in_ready, step_valid} !== 3'b100) begin
      failures++;
      $display("FAIL ovf_err: got err=%b rdy=%b sv=%b expected 1 0 0", err, in_ready, step_valid);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({done, err, line_count} !== {1'b0, 1'b1, 16'd1} || obs.size() != 1) begin
      failures++;
      $display("FAIL ovf_hold: got done=%b err=%b lines=%0d pulses=%0d expected 0 1 1 1",
               done, err, line_count, obs.size());
    end
  endtask

  task automatic test_parse_errors();
    do_reset();
    send_byte(8'h58, 1'b0, 0);
    checks++;
    if ({err, in_ready, step_valid, done} !== 4'b1000) begin
      failures++;
      $display("FAIL err_bad_dir: got err=%b rdy=%b sv=%b done=%b expected 1 0 0 0", err, in_ready, step_valid, done);
    end
    do_reset();
    send_byte(8'h4C, 1'b0, 0);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_early: err=%b after 'L' expected 0", err);
    end
    send_byte(8'h0A, 1'b0, 0);
    checks++;
    if ({err, in_ready, step_valid} !== 3'b100) begin
      failures++;
      $display("FAIL err_no_digit: got err=%b rdy=%b sv=%b expected 1 0 0", err, in_ready, step_valid);
    end
    do_reset();
    send_byte(8'h52, 1'b1, 0);
    checks++;
    if ({err, in_ready, step_valid} !== 3'b100) begin
      failures++;
      $display("FAIL err_last_dir: got err=%b rdy=%b sv=%b expected 1 0 0", err, in_ready, step_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({done, line_count} !== {1'b0, 16'd0} || obs.size() != 0) begin
      failures++;
      $display("FAIL err_last_hold: got done=%b lines=%0d pulses=%0d expected 0 0 0", done, line_count, obs.size());
    end
  endtask

  task automatic test_reset_midline();
    do_reset();
    send_byte(8'h52, 1'b0, 0);
    send_byte(8'h31, 1'b0, 0);
    send_byte(8'h32, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, step_valid, step_direction, step_count, done, err, line_count} !== '0) begin
      failures++;
      $display("FAIL midline_reset_outputs: got rdy=%b sv=%b dir=%b cnt=%0d done=%b err=%b lines=%0d expected all 0",
               in_ready, step_valid, step_direction, step_count, done, err, line_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    obs.delete();
    send_byte(8'h4C, 1'b0, 0);
    send_byte(8'h33, 1'b0, 0);
    send_byte(8'h0A, 1'b0, 0);
    checks++;
    if ({step_valid, step_direction, step_count, line_count} !== {1'b1, 1'b0, 10'd3, 16'd1}) begin
      failures++;
      $display("FAIL midline_l3: got sv=%b dir=%b cnt=%0d lines=%0d expected 1 0 3 1",
               step_valid, step_direction, step_count, line_count);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs.size() != 1) begin
      failures++;
      $display("FAIL midline_pulses: got %0d expected 1", obs.size());
    end
  endtask

  task automatic test_gaps();
    logic [7:0] bytes[7];
    logic [CW:0] e0, e1;
    bytes = '{8'h4C, 8'h36, 8'h38, 8'h0A, 8'h52, 8'h35, 8'h0A};
    e0 = {1'b0, 10'd68};
    e1 = {1'b1, 10'd5};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      send_byte(bytes[i], (i == 6), int'($urandom_range(5, 0)));
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs.size() != 2) begin
      failures++;
      $display("FAIL gaps_count: got %0d pulses expected 2", obs.size());
    end else begin
      checks++;
      if (obs[0] !== e0 || obs[1] !== e1) begin
        failures++;
        $display("FAIL gaps_cmds: got %h %h expected %h %h", obs[0], obs[1], e0, e1);
      end
    end
    checks++;
    if ({done, err, line_count} !== {1'b1, 1'b0, 16'd2}) begin
      failures++;
      $display("FAIL gaps_final: got done=%b err=%b lines=%0d expected 1 0 2", done, err, line_count);
    end
  endtask

  initial begin
    test_reset();
    test_two_lines();
    test_crlf_blank_last_digit();
    test_overflow();
    test_parse_errors();
    test_reset_midline();
    for (int r = 0; r < 3; r++) test_gaps();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
